// File: rtl/lane_reduction_arbiter.sv
// Round-robin read scheduler merging N_SRC lane_reduction sources
// into one valid/ready word stream through a credit-protected skid FIFO.
module lane_reduction_arbiter #(
  parameter int N_SRC        = 4,
  parameter int WIDTH        = 16,
  parameter int READ_LATENCY = 2,
  parameter int SKID_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_SRC-1:0]                  src_empty,
  output logic [N_SRC-1:0]                  src_read_en,
  input  logic [N_SRC-1:0]                  src_data_vd,
  input  logic [N_SRC-1:0][WIDTH-1:0]       src_data,
  input  logic [N_SRC-1:0]                  src_overflow,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [WIDTH-1:0]                  m_data,
  output logic [$clog2(N_SRC)-1:0]          m_src,
  output logic [N_SRC-1:0]                  overflow_sticky,
  input  logic                              clear_overflow
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = $clog2(SKID_DEPTH + 1);
  localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int RL = READ_LATENCY;

  logic [IW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]                  occ_q, occ_d;
  logic [CW-1:0]                  inflight_q, inflight_d;
  logic [RL-1:0]                  tag_vld_q;
  logic [RL-1:0][IW-1:0]          tag_idx_q;
  logic [SKID_DEPTH-1:0][WIDTH-1:0] mem_data_q;
  logic [SKID_DEPTH-1:0][IW-1:0]  mem_src_q;
  logic [AW-1:0]                  rd_ptr_q, wr_ptr_q;
  logic [N_SRC-1:0]               ovf_q, ovf_d, ovf_set;

  logic          credit, gnt_found, issue;
  logic [IW-1:0] gnt_idx, cand;
  logic          ex_vld, push, pop;
  logic [IW-1:0] ex_idx;
  logic [CW:0]   used;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(SKID_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // buffered words plus reads still in the source pipe share one budget
  assign used   = {1'b0, occ_q} + {1'b0, inflight_q};
  assign credit = (used < (CW+1)'(SKID_DEPTH));

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = IW'((int'(rr_ptr_q) + k) % N_SRC);
      if (!gnt_found && !src_empty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign issue = !rst && credit && gnt_found;

  always_comb begin
    src_read_en = '0;
    if (issue) src_read_en[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (gnt_idx == IW'(N_SRC - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  assign ex_vld = tag_vld_q[RL-1];
  assign ex_idx = tag_idx_q[RL-1];
  assign push   = ex_vld && src_data_vd[ex_idx];
  assign pop    = m_valid && m_ready;

  assign m_valid = (occ_q != '0);
  assign m_data  = m_valid ? mem_data_q[rd_ptr_q] : '0;
  assign m_src   = m_valid ? mem_src_q[rd_ptr_q] : '0;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, ex_vld})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // a flag raised in the clearing cycle survives the clear
  always_comb begin
    ovf_set = '0;
    if (ex_vld && src_overflow[ex_idx]) ovf_set[ex_idx] = 1'b1;
    ovf_d = clear_overflow ? ovf_set : (ovf_q | ovf_set);
  end

  assign overflow_sticky = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      tag_vld_q  <= '0;
      tag_idx_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      ovf_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      tag_vld_q[0] <= issue;
      tag_idx_q[0] <= gnt_idx;
      for (int i = 1; i < RL; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= src_data[ex_idx];
      mem_src_q[wr_ptr_q]  <= ex_idx;
    end
  end

endmodule

// File: tb/tb_lane_reduction_arbiter.sv
// Directed bench for lane_reduction_arbiter with source FIFO models
// and a queue-based output scoreboard.
module tb_lane_reduction_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int RL = 2;
  localparam int D  = 4;

  typedef struct packed {
    logic         vd;
    logic [W-1:0] d;
    logic         ovf;
  } ent_t;

  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] d;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      src_empty;
  logic [N-1:0]      src_read_en;
  logic [N-1:0]      src_data_vd;
  logic [N-1:0][W-1:0] src_data;
  logic [N-1:0]      src_overflow;
  logic              m_valid;
  logic              m_ready;
  logic [W-1:0]      m_data;
  logic [1:0]        m_src;
  logic [N-1:0]      overflow_sticky;
  logic              clear_overflow;

  ent_t srcq [N][$];
  ent_t pend [N];
  exp_t exp_q[$];
  exp_t mon_e;
  int   gnt_log[$];
  int   gnt_cyc[$];
  logic [N-1:0] req;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_out = 0;
  int last_out_cyc = 0;
  int n0, first_out, rcyc;
  int ord_a[4];
  int ord_b[4];

  always #5 clk = ~clk;

  lane_reduction_arbiter #(
    .N_SRC(N), .WIDTH(W), .READ_LATENCY(RL), .SKID_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .src_empty(src_empty),
    .src_read_en(src_read_en),
    .src_data_vd(src_data_vd),
    .src_data(src_data),
    .src_overflow(src_overflow),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .m_src(m_src),
    .overflow_sticky(overflow_sticky),
    .clear_overflow(clear_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req_v);
    end
  endtask

  function automatic int glog(input int i);
    if (i < gnt_log.size()) return gnt_log[i];
    return -1;
  endfunction

  function automatic int gcyc(input int i);
    if (i < gnt_cyc.size()) return gnt_cyc[i];
    return -1;
  endfunction

  function automatic logic [W-1:0] word(input int base, input int s,
                                        input int r);
    return W'(base + s * 256 + r);
  endfunction

  task automatic load(input int s, input logic vd, input logic [W-1:0] d,
                      input logic ovf);
    srcq[s].push_back({vd, d, ovf});
  endtask

  task automatic expect_w(input int s, input logic [W-1:0] d);
    exp_q.push_back({2'(s), d});
  endtask

  task automatic clr_log();
    gnt_log.delete();
    gnt_cyc.delete();
  endtask

  // one clock: sample grants mid-cycle, then advance the source models
  task automatic tick();
    @(negedge clk);
    req = src_read_en;
    if (req != '0) begin
      chk("read_en_onehot", $countones(req), 1);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          gnt_log.push_back(i);
          gnt_cyc.push_back(cyc);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      src_data_vd[i]  = pend[i].vd;
      src_data[i]     = pend[i].d;
      src_overflow[i] = pend[i].ovf;
      pend[i] = '0;
      if (req[i] && srcq[i].size() > 0) pend[i] = srcq[i].pop_front();
      src_empty[i] = (srcq[i].size() == 0);
    end
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      n_out++;
      last_out_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL out_unexpected: got src=%0d data=%h, required none",
                 m_src, m_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (m_src !== mon_e.src || m_data !== mon_e.d) begin
          failures++;
          $display("FAIL out_word: got src=%0d data=%h required src=%0d data=%h",
                   m_src, m_data, mon_e.src, mon_e.d);
        end
      end
    end
  end

  initial begin
    ord_a = '{3, 0, 1, 2};
    ord_b = '{1, 2, 3, 0};
    rst = 1'b1;
    m_ready = 1'b0;
    clear_overflow = 1'b0;
    src_empty = '1;
    src_data_vd = '0;
    src_data = '0;
    src_overflow = '0;
    for (int i = 0; i < N; i++) pend[i] = '0;

    // reset state, with a non-empty source present
    load(0, 1'b1, 16'hDEAD, 1'b1);
    run(3);
    chk("rst_read_en", src_read_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_ovf", overflow_sticky, 0);
    chk("rst_no_grant", gnt_log.size(), 0);
    srcq[0].delete();
    run(1);
    rst = 1'b0;
    m_ready = 1'b1;
    run(2);

    // single source
    clr_log();
    n0 = n_out;
    first_out = -1;
    load(2, 1'b1, 16'h1111, 1'b0);
    load(2, 1'b1, 16'h2222, 1'b0);
    expect_w(2, 16'h1111);
    expect_w(2, 16'h2222);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (first_out < 0 && n_out > n0) first_out = last_out_cyc;
    end
    chk("single_grants", gnt_log.size(), 2);
    chk("single_src_a", glog(0), 2);
    chk("single_src_b", glog(1), 2);
    chk("single_b2b", gcyc(1) - gcyc(0), 1);
    chk("single_latency", first_out - gcyc(0), 3);
    chk("single_words", n_out - n0, 2);

    // fairness, rr_ptr starts at 3
    clr_log();
    n0 = n_out;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < N; s++) load(s, 1'b1, word(16'hF000, s, r), 1'b0);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) expect_w(ord_a[k], word(16'hF000, ord_a[k], r));
    run(20);
    chk("fair_grants", gnt_log.size(), 12);
    for (int k = 0; k < 12; k++) chk("fair_order", glog(k), ord_a[k % 4]);
    chk("fair_rate", gcyc(11) - gcyc(0), 11);
    chk("fair_words", n_out - n0, 12);

    // empty lane slots
    clr_log();
    n0 = n_out;
    load(0, 1'b1, 16'h0A01, 1'b0);
    load(0, 1'b0, 16'h0A02, 1'b0);
    load(0, 1'b0, 16'h0A03, 1'b0);
    load(0, 1'b1, 16'h0A04, 1'b0);
    expect_w(0, 16'h0A01);
    expect_w(0, 16'h0A04);
    run(10);
    chk("empty_grants", gnt_log.size(), 4);
    chk("empty_nostall", gcyc(3) - gcyc(0), 3);
    chk("empty_words", n_out - n0, 2);

    // backpressure, rr_ptr starts at 1
    clr_log();
    m_ready = 1'b0;
    n0 = n_out;
    for (int r = 0; r < 3; r++)
      for (int s = 0; s < N; s++) load(s, 1'b1, word(16'hB000, s, r), 1'b0);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) expect_w(ord_b[k], word(16'hB000, ord_b[k], r));
    run(20);
    chk("bp_grants", gnt_log.size(), 4);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 16'hB100);
    chk("bp_src", m_src, 1);
    run(5);
    chk("bp_data_held", m_data, 16'hB100);
    chk("bp_grants_held", gnt_log.size(), 4);
    rcyc = cyc;
    m_ready = 1'b1;
    run(30);
    chk("bp_resume", gcyc(4), rcyc + 1);
    chk("bp_total", gnt_log.size(), 12);
    for (int k = 0; k < 12; k++) chk("bp_order", glog(k), ord_b[k % 4]);
    chk("bp_words", n_out - n0, 12);

    // overflow on an empty slot, rr_ptr starts at 1
    clr_log();
    n0 = n_out;
    load(1, 1'b0, 16'h0BAD, 1'b1);
    run(8);
    chk("ovf_set", overflow_sticky, 4'b0010);
    chk("ovf_no_word", n_out - n0, 0);
    clr_log();
    load(3, 1'b0, 16'h0BAD, 1'b1);
    for (int k = 0; k < 10 && gnt_log.size() == 0; k++) tick();
    chk("ovf_grant", glog(0), 3);
    tick();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_clear_set", overflow_sticky, 4'b1000);

    // mid-flight reset, rr_ptr would otherwise be 2
    clr_log();
    n0 = n_out;
    load(1, 1'b1, 16'h5555, 1'b0);
    for (int k = 0; k < 10 && gnt_log.size() == 0; k++) tick();
    chk("mrst_grant", glog(0), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(6);
    chk("mrst_no_word", n_out - n0, 0);
    chk("mrst_m_valid", m_valid, 0);
    chk("mrst_m_data", m_data, 0);
    chk("mrst_m_src", m_src, 0);
    chk("mrst_ovf", overflow_sticky, 0);
    clr_log();
    load(3, 1'b1, 16'h3333, 1'b0);
    load(0, 1'b1, 16'h0C0C, 1'b0);
    expect_w(0, 16'h0C0C);
    expect_w(3, 16'h3333);
    run(10);
    chk("mrst_next0", glog(0), 0);
    chk("mrst_next1", glog(1), 3);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
